// File: rtl/armleocpu_decode_pkg.sv
// Shared decode-stage constants: command encodings, stage type codes, RV32I
// opcodes, the stage FSM state type and a serializing-instruction helper.
package armleocpu_decode_pkg;

  localparam int unsigned F2E_TYPE_WIDTH = 2;
  localparam int unsigned D2E_TYPE_WIDTH = 2;
  localparam int unsigned D2F_CMD_WIDTH  = 2;

  // Decode/execute -> fetch commands
  localparam logic [D2F_CMD_WIDTH-1:0] D2F_CMD_NONE         = 2'd0;
  localparam logic [D2F_CMD_WIDTH-1:0] D2F_CMD_START_BRANCH = 2'd1;
  localparam logic [D2F_CMD_WIDTH-1:0] D2F_CMD_FLUSH        = 2'd2;

  // Fetch result kinds
  localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INSTR             = 2'd0;
  localparam logic [F2E_TYPE_WIDTH-1:0] F2E_TYPE_INTERRUPT_PENDING = 2'd1;

  // Decode result kinds
  localparam logic [D2E_TYPE_WIDTH-1:0] D2E_TYPE_INSTR             = 2'd0;
  localparam logic [D2E_TYPE_WIDTH-1:0] D2E_TYPE_ILLEGAL           = 2'd1;
  localparam logic [D2E_TYPE_WIDTH-1:0] D2E_TYPE_FETCH_ERROR       = 2'd2;
  localparam logic [D2E_TYPE_WIDTH-1:0] D2E_TYPE_INTERRUPT_PENDING = 2'd3;

  // RV32I major opcodes
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

  typedef enum logic {
    STATE_RUN       = 1'b0,
    STATE_WAIT_EXEC = 1'b1
  } state_t;

  // Instructions after which fetch must wait for execute to redirect it
  function automatic logic is_serializing(input logic [D2E_TYPE_WIDTH-1:0] dtype,
                                          input logic [31:0] instr);
    logic fence_i;
    fence_i = (instr[6:0] == OPCODE_MISC_MEM) && (instr[14:12] == 3'b001);
    return (dtype != D2E_TYPE_INSTR) || (instr[6:0] == OPCODE_SYSTEM) || fence_i;
  endfunction

endpackage

// File: rtl/armleocpu_decode_imm.sv
// Combinational immediate and result-type decode.
// Ports: instr (fetched word), fetch_type / resp (fetch status)
//        -> imm (sign-extended immediate), dtype (decode result kind).
module armleocpu_decode_imm
  import armleocpu_decode_pkg::*;
(
  input  logic [31:0]               instr,
  input  logic [F2E_TYPE_WIDTH-1:0] fetch_type,
  input  logic [3:0]                resp,
  output logic [31:0]               imm,
  output logic [D2E_TYPE_WIDTH-1:0] dtype
);

  logic illegal;

  // Immediate by instruction format; unknown opcodes decode as illegal
  always_comb begin
    imm     = 32'd0;
    illegal = 1'b0;
    case (instr[6:0])
      OPCODE_LOAD, OPCODE_OP_IMM, OPCODE_JALR, OPCODE_SYSTEM:
        imm = {{20{instr[31]}}, instr[31:20]};
      OPCODE_STORE:
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OPCODE_BRANCH:
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      OPCODE_LUI, OPCODE_AUIPC:
        imm = {instr[31:12], 12'd0};
      OPCODE_JAL:
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      OPCODE_OP, OPCODE_MISC_MEM:
        imm = 32'd0;
      default:
        illegal = 1'b1;
    endcase
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end
  end

  // Interrupt beats fetch error beats illegal encoding
  always_comb begin
    dtype = D2E_TYPE_INSTR;
    if (fetch_type == F2E_TYPE_INTERRUPT_PENDING) begin
      dtype = D2E_TYPE_INTERRUPT_PENDING;
    end else if (resp != 4'd0) begin
      dtype = D2E_TYPE_FETCH_ERROR;
    end else if (illegal) begin
      dtype = D2E_TYPE_ILLEGAL;
    end
  end

endmodule

// File: rtl/armleocpu_decode.sv
// Decode stage: registers fetched instructions toward execute, issues
// synchronous regfile reads, holds fetch after serializing instructions and
// forwards execute's branch/flush commands to fetch.
// Ports: clk, rst_n (sync, active-low); f2d_* fetch result in; d2f_ready /
//        d2f_cmd / d2f_branchtarget to fetch; e2d_* from execute; d2e_*
//        registered decode result; rs1/rs2 read enables and addresses.
module armleocpu_decode
  import armleocpu_decode_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      f2d_valid,
  input  logic [F2E_TYPE_WIDTH-1:0] f2d_type,
  input  logic [31:0]               f2d_instr,
  input  logic [31:0]               f2d_pc,
  input  logic [3:0]                f2d_resp,

  output logic                      d2f_ready,
  output logic [D2F_CMD_WIDTH-1:0]  d2f_cmd,
  output logic [31:0]               d2f_branchtarget,

  input  logic                      e2d_ready,
  input  logic [D2F_CMD_WIDTH-1:0]  e2d_cmd,
  input  logic [31:0]               e2d_branchtarget,

  output logic                      d2e_valid,
  output logic [D2E_TYPE_WIDTH-1:0] d2e_type,
  output logic [31:0]               d2e_instr,
  output logic [31:0]               d2e_pc,
  output logic [31:0]               d2e_imm,
  output logic [4:0]                d2e_rd,
  output logic [4:0]                d2e_rs1,
  output logic [4:0]                d2e_rs2,

  output logic                      rs1_read,
  output logic                      rs2_read,
  output logic [4:0]                rs1_addr,
  output logic [4:0]                rs2_addr
);

  state_t                    state;
  logic                      can_accept;
  logic                      accept;
  logic                      cmd_active;
  logic [31:0]               dec_imm;
  logic [D2E_TYPE_WIDTH-1:0] dec_type;

  armleocpu_decode_imm u_imm (
    .instr      (f2d_instr),
    .fetch_type (f2d_type),
    .resp       (f2d_resp),
    .imm        (dec_imm),
    .dtype      (dec_type)
  );

  assign can_accept = !d2e_valid || e2d_ready;
  assign cmd_active = (e2d_cmd != D2F_CMD_NONE);

  // Fetch handshake; an execute command overrides everything and drops f2d
  always_comb begin
    d2f_ready        = 1'b0;
    d2f_cmd          = D2F_CMD_NONE;
    d2f_branchtarget = 32'd0;
    accept           = 1'b0;
    if (rst_n) begin
      if (cmd_active) begin
        d2f_ready        = 1'b1;
        d2f_cmd          = e2d_cmd;
        d2f_branchtarget = e2d_branchtarget;
      end else if (state == STATE_RUN) begin
        d2f_ready = can_accept;
        accept    = f2d_valid && can_accept;
      end
    end
  end

  // Regfile read is launched in the accept cycle so data lines up with d2e
  assign rs1_read = accept;
  assign rs2_read = accept;
  assign rs1_addr = f2d_instr[19:15];
  assign rs2_addr = f2d_instr[24:20];

  // Stage state and output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= STATE_RUN;
      d2e_valid <= 1'b0;
      d2e_type  <= D2E_TYPE_INSTR;
      d2e_instr <= 32'd0;
      d2e_pc    <= 32'd0;
      d2e_imm   <= 32'd0;
      d2e_rd    <= 5'd0;
      d2e_rs1   <= 5'd0;
      d2e_rs2   <= 5'd0;
    end else if (cmd_active) begin
      state     <= STATE_RUN;
      d2e_valid <= 1'b0;
    end else if (accept) begin
      d2e_valid <= 1'b1;
      d2e_type  <= dec_type;
      d2e_instr <= f2d_instr;
      d2e_pc    <= f2d_pc;
      d2e_imm   <= dec_imm;
      d2e_rd    <= f2d_instr[11:7];
      d2e_rs1   <= f2d_instr[19:15];
      d2e_rs2   <= f2d_instr[24:20];
      if (is_serializing(dec_type, f2d_instr)) begin
        state <= STATE_WAIT_EXEC;
      end
    end else if (d2e_valid && e2d_ready) begin
      d2e_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_armleocpu_decode.sv
// Self-checking bench for armleocpu_decode: directed scenarios push expected
// decode results to a scoreboard that a monitor pops when execute consumes.
module tb_armleocpu_decode;
  import armleocpu_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f2d_valid;
  logic [1:0]  f2d_type;
  logic [31:0] f2d_instr;
  logic [31:0] f2d_pc;
  logic [3:0]  f2d_resp;
  logic        d2f_ready;
  logic [1:0]  d2f_cmd;
  logic [31:0] d2f_branchtarget;
  logic        e2d_ready;
  logic [1:0]  e2d_cmd;
  logic [31:0] e2d_branchtarget;
  logic        d2e_valid;
  logic [1:0]  d2e_type;
  logic [31:0] d2e_instr, d2e_pc, d2e_imm;
  logic [4:0]  d2e_rd, d2e_rs1, d2e_rs2;
  logic        rs1_read, rs2_read;
  logic [4:0]  rs1_addr, rs2_addr;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]  typ;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  armleocpu_decode dut (
    .clk(clk), .rst_n(rst_n),
    .f2d_valid(f2d_valid), .f2d_type(f2d_type), .f2d_instr(f2d_instr),
    .f2d_pc(f2d_pc), .f2d_resp(f2d_resp),
    .d2f_ready(d2f_ready), .d2f_cmd(d2f_cmd), .d2f_branchtarget(d2f_branchtarget),
    .e2d_ready(e2d_ready), .e2d_cmd(e2d_cmd), .e2d_branchtarget(e2d_branchtarget),
    .d2e_valid(d2e_valid), .d2e_type(d2e_type), .d2e_instr(d2e_instr),
    .d2e_pc(d2e_pc), .d2e_imm(d2e_imm), .d2e_rd(d2e_rd), .d2e_rs1(d2e_rs1),
    .d2e_rs2(d2e_rs2),
    .rs1_read(rs1_read), .rs2_read(rs2_read), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr)
  );

  // Scoreboard monitor: execute takes d2e whenever valid and ready
  always @(negedge clk) begin
    if (rst_n && d2e_valid && e2d_ready) begin
      exp_t e;
      logic [31:0] w;
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got instr=%h pc=%h, required no output", d2e_instr, d2e_pc);
      end else begin
        e = sb.pop_front();
        w = e.instr;
        if (d2e_type !== e.typ || d2e_instr !== e.instr || d2e_pc !== e.pc ||
            d2e_rd !== w[11:7] || d2e_rs1 !== w[19:15] || d2e_rs2 !== w[24:20] ||
            (e.typ == D2E_TYPE_INSTR && d2e_imm !== e.imm)) begin
          bad++;
          $display("FAIL sb_entry: got type=%0d instr=%h pc=%h imm=%h rd=%0d rs1=%0d rs2=%0d, required type=%0d instr=%h pc=%h imm=%h rd=%0d rs1=%0d rs2=%0d",
                   d2e_type, d2e_instr, d2e_pc, d2e_imm, d2e_rd, d2e_rs1, d2e_rs2,
                   e.typ, e.instr, e.pc, e.imm, w[11:7], w[19:15], w[24:20]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] t, input logic [31:0] instr,
                       input logic [31:0] pc, input logic [3:0] resp);
    f2d_valid = v;
    f2d_type  = t;
    f2d_instr = instr;
    f2d_pc    = pc;
    f2d_resp  = resp;
  endtask

  task automatic push(input logic [1:0] t, input logic [31:0] instr,
                      input logic [31:0] pc, input logic [31:0] imm);
    exp_t e;
    e.typ = t; e.instr = instr; e.pc = pc; e.imm = imm;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    e2d_ready = 1'b1;
    e2d_cmd = D2F_CMD_NONE;
    e2d_branchtarget = 32'h1234_5678;
    drive(1'b1, F2E_TYPE_INSTR, 32'h0051_0093, 32'h100, 4'd0);
    #1;
    total++;
    if (d2f_ready !== 1'b0 || d2f_cmd !== 2'd0 || rs1_read !== 1'b0 || rs2_read !== 1'b0) begin
      bad++;
      $display("FAIL reset_comb: got ready=%b cmd=%0d rs1r=%b rs2r=%b, required 0 0 0 0",
               d2f_ready, d2f_cmd, rs1_read, rs2_read);
    end
    tick();
    total++;
    if (d2e_valid !== 1'b0 || d2e_instr !== 32'd0 || d2e_pc !== 32'd0 || d2e_imm !== 32'd0 ||
        d2e_type !== 2'd0 || d2e_rd !== 5'd0) begin
      bad++;
      $display("FAIL reset_regs: got valid=%b instr=%h pc=%h imm=%h type=%0d rd=%0d, required all 0",
               d2e_valid, d2e_instr, d2e_pc, d2e_imm, d2e_type, d2e_rd);
    end
    tick();
    rst_n = 1'b1;
    drive(1'b0, F2E_TYPE_INSTR, 32'd0, 32'd0, 4'd0);
    tick();
  endtask

  task automatic test_addi();
    e2d_ready = 1'b1;
    drive(1'b1, F2E_TYPE_INSTR, 32'h0051_0093, 32'h100, 4'd0);
    #1;
    total++;
    if (d2f_ready !== 1'b1 || rs1_read !== 1'b1 || rs2_read !== 1'b1 || rs1_addr !== 5'd2 ||
        rs2_addr !== 5'd5 || d2f_cmd !== 2'd0 || d2f_branchtarget !== 32'd0) begin
      bad++;
      $display("FAIL addi_accept: got ready=%b rs1r=%b rs2r=%b a1=%0d a2=%0d cmd=%0d tgt=%h, required 1 1 1 2 5 0 0",
               d2f_ready, rs1_read, rs2_read, rs1_addr, rs2_addr, d2f_cmd, d2f_branchtarget);
    end
    push(D2E_TYPE_INSTR, 32'h0051_0093, 32'h100, 32'd5);
    tick();
    drive(1'b0, F2E_TYPE_INSTR, 32'd0, 32'd0, 4'd0);
    #1;
    total++;
    if (d2e_valid !== 1'b1 || d2e_imm !== 32'd5 || d2e_rd !== 5'd1 || d2e_rs1 !== 5'd2 ||
        rs1_read !== 1'b0) begin
      bad++;
      $display("FAIL addi_out: got valid=%b imm=%h rd=%0d rs1=%0d rs1r=%b, required 1 5 1 2 0",
               d2e_valid, d2e_imm, d2e_rd, d2e_rs1, rs1_read);
    end
    tick();
    total++;
    if (d2e_valid !== 1'b0) begin
      bad++;
      $display("FAIL addi_drain: got valid=%b, required 0", d2e_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] instrs [11];
    logic [31:0] imms   [11];
    instrs[0]  = 32'h0051_0093; imms[0]  = 32'h0000_0005; // addi +5
    instrs[1]  = 32'hFFF0_0093; imms[1]  = 32'hFFFF_FFFF; // addi -1
    instrs[2]  = 32'h1234_50B7; imms[2]  = 32'h1234_5000; // lui
    instrs[3]  = 32'h0000_1117; imms[3]  = 32'h0000_1000; // auipc
    instrs[4]  = 32'hFE20_8EE3; imms[4]  = 32'hFFFF_FFFC; // beq -4
    instrs[5]  = 32'h0080_006F; imms[5]  = 32'h0000_0008; // jal +8
    instrs[6]  = 32'hFE11_2E23; imms[6]  = 32'hFFFF_FFFC; // sw -4
    instrs[7]  = 32'h0000_2183; imms[7]  = 32'h0000_0000; // lw
    instrs[8]  = 32'h0020_81B3; imms[8]  = 32'h0000_0000; // add
    instrs[9]  = 32'hFFC0_8067; imms[9]  = 32'hFFFF_FFFC; // jalr -4
    instrs[10] = 32'h0FF0_000F; imms[10] = 32'h0000_0000; // fence
    e2d_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, F2E_TYPE_INSTR, instrs[i], 32'h400 + 32'(i * 4), 4'd0);
      #1;
      total++;
      if (d2f_ready !== 1'b1 || (i > 0 && d2e_valid !== 1'b1)) begin
        bad++;
        $display("FAIL b2b_rate[%0d]: got ready=%b valid=%b, required 1 1", i, d2f_ready, d2e_valid);
      end
      push(D2E_TYPE_INSTR, instrs[i], 32'h400 + 32'(i * 4), imms[i]);
      tick();
    end
    drive(1'b0, F2E_TYPE_INSTR, 32'd0, 32'd0, 4'd0);
    tick();
    tick();
  endtask

  task automatic test_stall();
    e2d_ready = 1'b0;
    drive(1'b1, F2E_TYPE_INSTR, 32'h0051_0093, 32'h500, 4'd0);
    push(D2E_TYPE_INSTR, 32'h0051_0093, 32'h500, 32'd5);
    tick();
    drive(1'b1, F2E_TYPE_INSTR, 32'h1234_50B7, 32'h504, 4'd0);
    for (int n = 0; n < 3; n++) begin
      #1;
      total++;
      if (d2f_ready !== 1'b0 || rs1_read !== 1'b0 || d2e_valid !== 1'b1 ||
          d2e_instr !== 32'h0051_0093 || d2e_pc !== 32'h500 || d2e_imm !== 32'd5) begin
        bad++;
        $display("FAIL stall_hold[%0d]: got ready=%b rs1r=%b valid=%b instr=%h pc=%h imm=%h, required 0 0 1 00510093 00000500 5",
                 n, d2f_ready, rs1_read, d2e_valid, d2e_instr, d2e_pc, d2e_imm);
      end
      tick();
    end
    e2d_ready = 1'b1;
    #1;
    total++;
    if (d2f_ready !== 1'b1 || rs1_read !== 1'b1) begin
      bad++;
      $display("FAIL stall_release: got ready=%b rs1r=%b, required 1 1", d2f_ready, rs1_read);
    end
    push(D2E_TYPE_INSTR, 32'h1234_50B7, 32'h504, 32'h1234_5000);
    tick();
    drive(1'b0, F2E_TYPE_INSTR, 32'd0, 32'd0, 4'd0);
    tick();
  endtask

  task automatic test_serialize_branch();
    e2d_ready = 1'b1;
    drive(1'b1, F2E_TYPE_INSTR, 32'h3402_9073, 32'h200, 4'd0);
    push(D2E_TYPE_INSTR, 32'h3402_9073, 32'h200, 32'h0000_0340);
    tick();
    drive(1'b1, F2E_TYPE_INSTR, 32'h0051_0093, 32'h204, 4'd0);
    #1;
    total++;
    if (d2f_ready !== 1'b0 || rs1_read !== 1'b0) begin
      bad++;
      $display("FAIL csr_wait: got ready=%b rs1r=%b, required 0 0", d2f_ready, rs1_read);
    end
    tick();
    e2d_cmd = D2F_CMD_START_BRANCH;
    e2d_branchtarget = 32'h8000_0004;
    #1;
    total++;
    if (d2e_valid !== 1'b0 || d2f_ready !== 1'b1 || d2f_cmd !== D2F_CMD_START_BRANCH ||
        d2f_branchtarget !== 32'h8000_0004) begin
      bad++;
      $display("FAIL branch_cmd: got valid=%b ready=%b cmd=%0d tgt=%h, required 0 1 1 80000004",
               d2e_valid, d2f_ready, d2f_cmd, d2f_branchtarget);
    end
    tick();
    e2d_cmd = D2F_CMD_NONE;
    drive(1'b0, F2E_TYPE_INSTR, 32'd0, 32'd0, 4'd0);
    #1;
    total++;
    if (d2e_valid !== 1'b0 || d2f_ready !== 1'b1 || d2f_cmd !== 2'd0 || d2f_branchtarget !== 32'd0) begin
      bad++;
      $display("FAIL branch_run: got valid=%b ready=%b cmd=%0d tgt=%h, required 0 1 0 0",
               d2e_valid, d2f_ready, d2f_cmd, d2f_branchtarget);
    end
    tick();
  endtask

  task automatic test_flush();
    e2d_ready = 1'b1;
    drive(1'b1, F2E_TYPE_INSTR, 32'h0051_0093, 32'h300, 4'd0);
    push(D2E_TYPE_INSTR, 32'h0051_0093, 32'h300, 32'd5);
    tick();
    drive(1'b1, F2E_TYPE_INSTR, 32'h0020_81B3, 32'h304, 4'd0);
    e2d_cmd = D2F_CMD_FLUSH;
    e2d_branchtarget = 32'h0000_0abc;
    #1;
    total++;
    if (d2f_cmd !== D2F_CMD_FLUSH || d2f_ready !== 1'b1 || d2f_branchtarget !== 32'h0000_0abc) begin
      bad++;
      $display("FAIL flush_cmd: got cmd=%0d ready=%b tgt=%h, required 2 1 00000abc",
               d2f_cmd, d2f_ready, d2f_branchtarget);
    end
    tick();
    e2d_cmd = D2F_CMD_NONE;
    drive(1'b0, F2E_TYPE_INSTR, 32'd0, 32'd0, 4'd0);
    #1;
    total++;
    if (d2e_valid !== 1'b0) begin
      bad++;
      $display("FAIL flush_drop: got valid=%b, required 0", d2e_valid);
    end
    tick();
  endtask

  task automatic test_exceptions();
    logic [31:0] instrs [4];
    logic [1:0]  ftype  [4];
    logic [3:0]  resps  [4];
    logic [1:0]  etype  [4];
    instrs[0] = 32'h0000_0000; ftype[0] = F2E_TYPE_INSTR; resps[0] = 4'd0; etype[0] = D2E_TYPE_ILLEGAL;
    instrs[1] = 32'h0000_005B; ftype[1] = F2E_TYPE_INSTR; resps[1] = 4'd0; etype[1] = D2E_TYPE_ILLEGAL;
    instrs[2] = 32'h0051_0093; ftype[2] = F2E_TYPE_INSTR; resps[2] = 4'd1; etype[2] = D2E_TYPE_FETCH_ERROR;
    instrs[3] = 32'h0000_0000; ftype[3] = F2E_TYPE_INTERRUPT_PENDING; resps[3] = 4'd1;
    etype[3] = D2E_TYPE_INTERRUPT_PENDING;
    e2d_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, ftype[i], instrs[i], 32'h600 + 32'(i * 16), resps[i]);
      push(etype[i], instrs[i], 32'h600 + 32'(i * 16), 32'd0);
      tick();
      drive(1'b1, F2E_TYPE_INSTR, 32'h0051_0093, 32'h700, 4'd0);
      #1;
      total++;
      if (d2e_valid !== 1'b1 || d2e_type !== etype[i] || d2f_ready !== 1'b0) begin
        bad++;
        $display("FAIL exc_wait[%0d]: got valid=%b type=%0d ready=%b, required 1 %0d 0",
                 i, d2e_valid, d2e_type, d2f_ready, etype[i]);
      end
      tick();
      e2d_cmd = D2F_CMD_FLUSH;
      drive(1'b0, F2E_TYPE_INSTR, 32'd0, 32'd0, 4'd0);
      tick();
      e2d_cmd = D2F_CMD_NONE;
      #1;
      total++;
      if (d2f_ready !== 1'b1 || d2e_valid !== 1'b0) begin
        bad++;
        $display("FAIL exc_resume[%0d]: got ready=%b valid=%b, required 1 0", i, d2f_ready, d2e_valid);
      end
      tick();
    end
  endtask

  task automatic test_reset_wait_exec();
    e2d_ready = 1'b0;
    drive(1'b1, F2E_TYPE_INSTR, 32'h3402_9073, 32'h800, 4'd0);
    tick();
    drive(1'b0, F2E_TYPE_INSTR, 32'd0, 32'd0, 4'd0);
    rst_n = 1'b0;
    #1;
    total++;
    if (d2f_ready !== 1'b0 || d2f_cmd !== 2'd0 || d2e_valid !== 1'b1) begin
      bad++;
      $display("FAIL rst_wait_comb: got ready=%b cmd=%0d valid=%b, required 0 0 1",
               d2f_ready, d2f_cmd, d2e_valid);
    end
    tick();
    total++;
    if (d2e_valid !== 1'b0 || d2f_ready !== 1'b0 || d2f_cmd !== 2'd0) begin
      bad++;
      $display("FAIL rst_wait_held: got valid=%b ready=%b cmd=%0d, required 0 0 0",
               d2e_valid, d2f_ready, d2f_cmd);
    end
    sb.delete();
    rst_n = 1'b1;
    e2d_ready = 1'b1;
    #1;
    total++;
    if (d2f_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_wait_run: got ready=%b, required 1", d2f_ready);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    e2d_ready = 1'b0;
    e2d_cmd = D2F_CMD_NONE;
    e2d_branchtarget = 32'd0;
    drive(1'b0, F2E_TYPE_INSTR, 32'd0, 32'd0, 4'd0);
    #2;
    test_reset();
    test_addi();
    test_back_to_back();
    test_stall();
    test_serialize_branch();
    test_flush();
    test_exceptions();
    test_reset_wait_exec();
    tick();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending entries, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
